// File: rtl/ads_emu_pkg.sv
// rtl/ads_emu_pkg.sv - shared types and constants for the ADS8528 emulator
package ads_emu_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 8;
    localparam int IDX_W  = 16;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CONVERT = 2'd1;
    localparam state_t ST_STANDBY = 2'd2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ads_emu_sample_gen.sv
// rtl/ads_emu_sample_gen.sv - combinational ping/noise sample values for all channels (ADS_EMU_NOISE_EN adds noise)
module ads_emu_sample_gen
    import ads_emu_pkg::*;
#(
    parameter int      PULSE_PERIOD = 4096,
    parameter int      PULSE_LEN    = 64,
    parameter sample_t PULSE_AMP    = 16'sd8192,
    parameter int      CH_DELAY     = 3
`ifdef ADS_EMU_NOISE_EN
    , parameter logic [15:0] NOISE_MASK = 16'h001F
`endif
) (
    input  logic [IDX_W-1:0]               idx_i,
`ifdef ADS_EMU_NOISE_EN
    input  logic [15:0]                    lfsr_i,
`endif
    output logic [NUM_CH-1:0][DATA_W-1:0]  samples_o
);

    // Per channel: phase k within the ping period, alternating-sign ping, optional noise, saturate
    always_comb begin
        int k;
        int v;
`ifdef ADS_EMU_NOISE_EN
        logic [15:0] rot;
        rot = '0;
`endif
        k = 0;
        v = 0;
        samples_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Channel offset is a constant, so no run-time modulo is needed
            k = int'(idx_i) - ((i * CH_DELAY) % PULSE_PERIOD);
            if (k < 0) begin
                k = k + PULSE_PERIOD;
            end
            if (k < PULSE_LEN) begin
                v = k[0] ? -int'(PULSE_AMP) : int'(PULSE_AMP);
            end else begin
                v = 0;
            end
`ifdef ADS_EMU_NOISE_EN
            rot = (lfsr_i << i) | (lfsr_i >> (16 - i));
            v = v + int'({16'b0, rot & NOISE_MASK}) - int'({16'b0, NOISE_MASK >> 1});
`endif
            if (v > 32767) begin
                v = 32767;
            end else if (v < -32767) begin
                v = -32767;
            end
            samples_o[i] = v[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/ads8528_emulator.sv
// rtl/ads8528_emulator.sv - ADS8528 responder: sync inputs, conversion FSM, result regs, readout (ADS_EMU_NOISE_EN adds LFSR noise)
module ads8528_emulator
    import ads_emu_pkg::*;
#(
    parameter int      CONV_CYCLES  = 24,
    parameter int      PULSE_PERIOD = 4096,
    parameter int      PULSE_LEN    = 64,
    parameter sample_t PULSE_AMP    = 16'sd8192,
    parameter int      CH_DELAY     = 3
`ifdef ADS_EMU_NOISE_EN
    , parameter logic [15:0] NOISE_MASK = 16'h001F
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        convst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              stby_n,
    output logic              busy,
    output logic [DATA_W-1:0] db_o,
    output logic              db_oe,
    output logic              overrun,
    output logic [15:0]       conv_count
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int PTR_W = $clog2(NUM_CH);

    logic [3:0] cv_s1_q, cv_s2_q, cv_p_q;
    logic [2:0] ct_s1_q, ct_s2_q;           // {stby_n, rd_n, cs_n}
    logic       rd_p_q;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0]                    mask_q, mask_d;
    logic                          busy_q, busy_d;
    logic                          done, ovr_set;
    logic                          overrun_q;
    logic [15:0]                   count_q;
    logic [IDX_W-1:0]              idx_q;
    logic [NUM_CH-1:0][DATA_W-1:0] result_q;
    logic [NUM_CH-1:0][DATA_W-1:0] samples;
    logic [PTR_W-1:0]              ptr_q;
    logic [DATA_W-1:0]             db_q;
    logic                          oe_q;

    wire       cs_s     = ct_s2_q[0];
    wire       rd_s     = ct_s2_q[1];
    wire       stby_s   = ct_s2_q[2];
    wire [3:0] cv_rise  = cv_s2_q & ~cv_p_q;
    wire       rd_fall  = ~rd_s & rd_p_q;

`ifdef ADS_EMU_NOISE_EN
    logic [15:0] lfsr_q;

    // Noise source steps once per completed conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      lfsr_q <= LFSR_SEED;
        else if (done) lfsr_q <= lfsr_step(lfsr_q);
    end

    ads_emu_sample_gen #(
        .PULSE_PERIOD(PULSE_PERIOD), .PULSE_LEN(PULSE_LEN), .PULSE_AMP(PULSE_AMP),
        .CH_DELAY(CH_DELAY), .NOISE_MASK(NOISE_MASK)
    ) u_gen (.idx_i(idx_q), .lfsr_i(lfsr_q), .samples_o(samples));
`else
    ads_emu_sample_gen #(
        .PULSE_PERIOD(PULSE_PERIOD), .PULSE_LEN(PULSE_LEN), .PULSE_AMP(PULSE_AMP),
        .CH_DELAY(CH_DELAY)
    ) u_gen (.idx_i(idx_q), .samples_o(samples));
`endif

    // Two-flop synchronizers plus previous-value registers for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cv_s1_q <= '0;
            cv_s2_q <= '0;
            cv_p_q  <= '0;
            ct_s1_q <= 3'b111;
            ct_s2_q <= 3'b111;
            rd_p_q  <= 1'b1;
        end else begin
            cv_s1_q <= convst;
            cv_s2_q <= cv_s1_q;
            cv_p_q  <= cv_s2_q;
            ct_s1_q <= {stby_n, rd_n, cs_n};
            ct_s2_q <= ct_s1_q;
            rd_p_q  <= rd_s;
        end
    end

    // Conversion FSM next state; standby overrides everything and aborts a conversion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done    = 1'b0;
        ovr_set = 1'b0;
        if (!stby_s) begin
            state_d = ST_STANDBY;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|cv_rise) begin
                        state_d = ST_CONVERT;
                        mask_d  = cv_rise;
                        cnt_d   = '0;
                    end
                end
                ST_CONVERT: begin
                    ovr_set = |cv_rise;
                    if (cnt_q == CNT_W'(CONV_CYCLES)) begin
                        done    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        busy_d = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, result registers and readout bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            ptr_q     <= '0;
            db_q      <= '0;
            oe_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            oe_q    <= ~cs_s & ~rd_s & stby_s;
            if (ovr_set) overrun_q <= 1'b1;
            if (rd_fall && !cs_s) begin
                db_q  <= result_q[ptr_q];
                ptr_q <= ptr_q + 1'b1;
            end
            if (done) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (mask_q[i >> 1]) result_q[i] <= samples[i];
                end
                ptr_q   <= '0;
                count_q <= count_q + 16'd1;
                idx_q   <= (idx_q == IDX_W'(PULSE_PERIOD - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign busy       = busy_q;
    assign db_o       = db_q;
    assign db_oe      = oe_q;
    assign overrun    = overrun_q;
    assign conv_count = count_q;

endmodule

// File: tb/tb_ads8528_emulator.sv
// tb/tb_ads8528_emulator.sv - self-checking bench for ads8528_emulator against a spec-level model
module tb_ads8528_emulator;

    localparam int CONV   = 24;
    localparam int PERIOD = 4096;
    localparam int PLEN   = 64;
    localparam int DELAY  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  convst;
    logic        cs_n, rd_n, stby_n;
    logic        busy, db_oe, overrun;
    logic [15:0] db_o, conv_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_res [8];
    int          m_idx, m_ptr, m_count;
    logic        m_ovr;

    ads8528_emulator dut (
        .clk(clk), .rst(rst), .convst(convst), .cs_n(cs_n), .rd_n(rd_n), .stby_n(stby_n),
        .busy(busy), .db_o(db_o), .db_oe(db_oe), .overrun(overrun), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_sample(input int ch, input int n);
        int k;
        k = ((n - ch * DELAY) % PERIOD + PERIOD) % PERIOD;
        if (k < PLEN) return (k % 2 == 0) ? 16'h2000 : 16'hE000;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_res[i] = 16'h0000;
        m_idx = 0; m_ptr = 0; m_count = 0; m_ovr = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One conversion; optionally a second convst edge partway through
    task automatic do_conv(input logic [3:0] m, input bit ovr_pulse);
        int n;
        convst = m;
        ticks(3);
        chk("busy_before_rise", busy, 0);
        ticks(1);
        chk("busy_rise", busy, 1);
        convst = 4'h0;
        n = 1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ovr_pulse && n == 8) convst = m;
            if (busy !== 1'b1) break;
            n++;
        end
        convst = 4'h0;
        chk("busy_len", n, CONV);
        for (int i = 0; i < 8; i++)
            if (m[i / 2]) exp_res[i] = ref_sample(i, m_idx);
        m_idx   = (m_idx + 1) % PERIOD;
        m_count = (m_count + 1) % 65536;
        m_ptr   = 0;
        if (ovr_pulse) m_ovr = 1'b1;
        chk("conv_count", conv_count, m_count);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic do_read(input bit toggle_cs);
        logic [15:0] e;
        cs_n = 1'b0;
        rd_n = 1'b0;
        ticks(4);
        e = exp_res[m_ptr];
        chk("oe_reading", db_oe, 1);
        chk($sformatf("db_ch%0d", m_ptr), db_o, e);
        m_ptr = (m_ptr + 1) % 8;
        rd_n = 1'b1;
        ticks(4);
        chk("db_hold", db_o, e);
        chk("oe_rd_high", db_oe, 0);
        if (toggle_cs) begin
            cs_n = 1'b1;
            ticks(4);
            chk("oe_cs_high", db_oe, 0);
        end
    endtask

    initial begin
        rst = 1'b0; convst = 4'h0; cs_n = 1'b1; rd_n = 1'b1; stby_n = 1'b1;
        model_reset();
        ticks(3);
        chk("rst_busy", busy, 0);
        chk("rst_db", db_o, 0);
        chk("rst_oe", db_oe, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_count", conv_count, 0);
        rst = 1'b1;
        ticks(5);

        // First conversion on pair A, then 9 reads to show pointer wrap
        do_conv(4'b0001, 1'b0);
        for (int r = 0; r < 9; r++) do_read(r == 4);
        cs_n = 1'b1;

        // Ten full conversions walk the ping across channels
        for (int c = 0; c < 10; c++) begin
            do_conv(4'hF, 1'b0);
            for (int r = 0; r < 8; r++) do_read(1'b0);
            cs_n = 1'b1;
        end

        // Only pair B updates
        do_conv(4'b0010, 1'b0);
        for (int r = 0; r < 8; r++) do_read(1'b1);

        // Second edge mid-conversion: overrun, single count
        do_conv(4'hF, 1'b1);
        ticks(40);
        chk("ovr_no_extra_busy", busy, 0);
        chk("ovr_single_count", conv_count, m_count);
        for (int r = 0; r < 8; r++) do_read(1'b0);
        cs_n = 1'b1;

        // Standby aborts a conversion and ignores convst
        convst = 4'hF;
        ticks(4);
        convst = 4'h0;
        ticks(10);
        chk("stby_busy_before", busy, 1);
        stby_n = 1'b0;
        ticks(3);
        chk("stby_busy_drop", busy, 0);
        convst = 4'hF;
        ticks(4);
        convst = 4'h0;
        ticks(4);
        chk("stby_convst_ignored", busy, 0);
        stby_n = 1'b1;
        ticks(8);
        chk("stby_exit_busy", busy, 0);
        chk("stby_count", conv_count, m_count);
        for (int r = 0; r < 8; r++) do_read(1'b0);
        cs_n = 1'b1;
        do_conv(4'hF, 1'b0);
        for (int r = 0; r < 8; r++) do_read(1'b0);
        cs_n = 1'b1;

        // Randomized conversions and reads
        for (int it = 0; it < 15; it++) begin
            logic [3:0] m;
            int nr;
            m = 4'($urandom_range(1, 15));
            do_conv(m, 1'b0);
            nr = $urandom_range(0, 10);
            for (int r = 0; r < nr; r++) do_read(1'($urandom_range(0, 1)));
            cs_n = 1'b1;
            ticks($urandom_range(0, 5));
        end

        // Asynchronous reset in the middle of a conversion
        convst = 4'h1;
        ticks(10);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count", conv_count, 0);
        chk("arst_db", db_o, 0);
        chk("arst_ovr", overrun, 0);
        convst = 4'h0;
        model_reset();
        ticks(2);
        rst = 1'b1;
        ticks(5);
        do_conv(4'hF, 1'b0);
        for (int r = 0; r < 8; r++) do_read(1'b0);
        cs_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ads8528_emulator.md
Name: ads8528_emulator

Overview:
- Synthesizable stand-in for the ADS8528 ADC: the responder end of the parallel ADC interface driven by the capture-side driver FSM.
- Responds to CONVST with BUSY and drives 8 channels of 16-bit two's-complement samples onto the data bus on RD_N/CS_N strobes.
- Sample content is a synthetic hydrophone ping, delayed per channel, so the whole capture → FIFO → SPI chain can be tested on hardware without the analog front end.
- Sits in a second FPGA or in the top level behind a build switch, wired pin-for-pin in place of the ADC.

Parameters:
- DATA_W, 16, sample width.
- NUM_CH, 8, channel count (4 pairs A..D).
- CONV_CYCLES, 24, clk cycles BUSY stays high per conversion.
- PULSE_PERIOD, 4096, conversions between ping starts.
- PULSE_LEN, 64, conversions per ping.
- PULSE_AMP, 16'sd8192, ping amplitude.
- CH_DELAY, 3, extra conversions of ping delay per channel index.
- NOISE_MASK, 16'h001F, LFSR bits kept as noise magnitude.

Ports:
- clk, in, 1, emulator clock; must be ≥ 4x the driver clock.
- rst, in, 1, asynchronous, active-low reset.
- convst, in, 4, CONVST_A..D from driver (bit0 = A).
- cs_n, in, 1, chip select.
- rd_n, in, 1, read strobe.
- stby_n, in, 1, standby, active low.
- busy, out, 1, conversion in progress.
- db_o, out, DATA_W, data bus drive value.
- db_oe, out, 1, bus drive enable; the top level builds the tristate.
- overrun, out, 1, sticky: CONVST edge seen while busy.
- conv_count, out, 16, completed conversions, wraps at 65535 → 0.

Behaviour:
- convst, cs_n, rd_n, stby_n pass through 2-FF synchronizers; edge detect runs on synced values. Input-to-action latency is 3 clk.
- Reset values: busy 0, db_o 0, db_oe 0, overrun 0, conv_count 0. Internally: channel pointer 0, sample index 0, result registers 0, LFSR 16'hACE1, state IDLE.
- FSM states IDLE, CONVERT, STANDBY.
- IDLE → CONVERT on a rising edge of any convst bit. Latch the triggering-pair mask. busy rises the next clk.
- CONVERT: busy held for exactly CONV_CYCLES clk, then busy falls and the FSM returns to IDLE.
  - On the cycle busy falls, result registers of triggered pairs (channels 2p, 2p+1) load new samples; untriggered pairs keep their old values.
  - Channel pointer resets to 0; conv_count increments; sample index advances modulo PULSE_PERIOD.
- A convst rising edge during CONVERT is ignored and sets overrun. overrun clears only on reset.
- Readout:
  - db_oe = synced (~cs_n & ~rd_n) & stby_n.
  - Each synced rd_n falling edge while cs_n is low drives db_o = result[pointer] and then increments the pointer, wrapping 7 → 0. First read after a conversion returns CH0.
  - db_o holds between reads.
  - Reads during CONVERT return the previous results; the pointer still advances.
  - A cs_n rising edge does not reset the pointer.
- Sample generation for channel i at index n: let k = n − i*CH_DELAY, computed mod PULSE_PERIOD.
  - If k < PULSE_LEN: value = +PULSE_AMP for even k, −PULSE_AMP for odd k.
  - Otherwise: value = 0 (baseline).
  - All arithmetic is signed DATA_W; the noise sum saturates at ±32767.
- stby_n low (synced): go to STANDBY from any state. Any conversion in progress is aborted, so results are not updated. busy = 0, db_oe = 0, convst ignored.
- STANDBY → IDLE once stby_n is synced high.
- Reset mid-conversion: all registers return to reset values immediately (asynchronous).

Optional Feature:
- Macro ADS_EMU_NOISE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) steps once per conversion. Each channel adds a signed noise term: (lfsr rotated by i) & NOISE_MASK, minus NOISE_MASK/2.
- Undefined: no LFSR is instantiated and the baseline is exactly 0. This gives deterministic data for scoreboards.

Decomposition:
- Package ads_emu_pkg holds the state enum type, DATA_W, NUM_CH, the LFSR seed/taps constants, and a sample_t signed typedef.
- One natural sub-module: ads_emu_sample_gen. It takes the sample index and LFSR and combinationally produces all NUM_CH sample values. The top module keeps the synchronizers, FSM, result registers and bus logic.

Test Plan:
- Reset, then a single convst[0] pulse: busy high for exactly 24 clk starting 4 clk after the pulse. Eight reads return CH0 = +8192 and CH1..7 ≠ ping for index 0; conv_count = 1.
- 10 full conversions (all 4 convst bits), noise off: CH3 shows +8192 first at index 9. At index 10 it shows −8192.
- convst = 4'b0010 only: CH2/CH3 update; CH0, CH1, CH4..CH7 keep prior values.
- Second convst edge 10 clk into a conversion: overrun = 1; busy still falls at 24 clk; conv_count increments by 1 only.
- 9 reads after one conversion: the 9th returns CH0 again (wrap). db_oe is high only while cs_n and rd_n are both low.
- stby_n low mid-conversion: busy drops within 3 clk and results are unchanged. After stby_n returns high, the next convst converts normally.
